// File: rtl/ycr1_wb_sram_bridge.sv
// Wishbone data-port slave mapped onto a single-port synchronous SRAM macro.
// Optional read-data register stage: define YCR1_SRAM_RDATA_REG_EN.
module ycr1_wb_sram_bridge #(
    parameter int          SRAM_AW   = 9,
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F800,
    parameter int          RD_LAT    = 1
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    input  logic               wbd_stb_i,
    input  logic [31:0]        wbd_adr_i,
    input  logic               wbd_we_i,
    input  logic [31:0]        wbd_dat_i,
    input  logic [3:0]         wbd_sel_i,
    output logic [31:0]        wbd_dat_o,
    output logic               wbd_ack_o,
    output logic               wbd_err_o,
    output logic               sram_csb_o,
    output logic               sram_web_o,
    output logic [3:0]         sram_wmask_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_din_o,
    input  logic [31:0]        sram_dout_i
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCESS = 3'd1;
    localparam logic [2:0] ST_RWAIT  = 3'd2;
    localparam logic [2:0] ST_RDREG  = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam logic [1:0] LAT_LOAD  = 2'(RD_LAT - 1);

    // State reached once the SRAM read data is valid.
`ifdef YCR1_SRAM_RDATA_REG_EN
    localparam logic [2:0] ST_RDONE  = ST_RDREG;
`else
    localparam logic [2:0] ST_RDONE  = ST_ACK;
`endif

    logic [2:0]         state_reg, state_next;
    logic [1:0]         cnt_reg, cnt_next;
    logic               rd_reg, rd_next;
    logic               ack_reg, ack_next;
    logic               err_reg, err_next;
    logic               csb_reg, csb_next;
    logic               web_reg, web_next;
    logic [3:0]         wmask_reg, wmask_next;
    logic [SRAM_AW-1:0] addr_reg, addr_next;
    logic [31:0]        din_reg, din_next;

    logic               hit;
    logic               sel_ok;

    assign hit    = ((wbd_adr_i & ADDR_MASK) == BASE_ADDR);
    assign sel_ok = |wbd_sel_i;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rd_next    = rd_reg;
        csb_next   = csb_reg;
        web_next   = web_reg;
        wmask_next = wmask_reg;
        addr_next  = addr_reg;
        din_next   = din_reg;

        case (state_reg)
            ST_IDLE: begin
                if (wbd_stb_i) begin
                    if (hit && sel_ok) begin
                        csb_next   = 1'b0;
                        web_next   = ~wbd_we_i;
                        wmask_next = wbd_sel_i;
                        addr_next  = wbd_adr_i[SRAM_AW+1:2];
                        din_next   = wbd_dat_i;
                        rd_next    = ~wbd_we_i;
                        state_next = ST_ACCESS;
                    end else begin
                        rd_next    = 1'b0;
                        state_next = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                csb_next = 1'b1;
                web_next = 1'b1;
                if (rd_reg) begin
                    cnt_next = LAT_LOAD;
                    if (RD_LAT > 1) begin
                        state_next = ST_RWAIT;
                    end else begin
                        state_next = ST_RDONE;
                    end
                end else begin
                    state_next = ST_ACK;
                end
            end
            ST_RWAIT: begin
                cnt_next = cnt_reg - 2'd1;
                // Leave on the cycle the counter hits zero; <=1 also guards a stray zero.
                if (cnt_reg <= 2'd1) begin
                    state_next = ST_RDONE;
                end
            end
            ST_RDREG: begin
                state_next = ST_ACK;
            end
            ST_ACK, ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ack_next = (state_next == ST_ACK) || (state_next == ST_ERR);
    assign err_next = (state_next == ST_ERR);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            rd_reg    <= 1'b0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            csb_reg   <= 1'b1;
            web_reg   <= 1'b1;
            wmask_reg <= 4'd0;
            addr_reg  <= '0;
            din_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rd_reg    <= rd_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            csb_reg   <= csb_next;
            web_reg   <= web_next;
            wmask_reg <= wmask_next;
            addr_reg  <= addr_next;
            din_reg   <= din_next;
        end
    end

    logic [31:0] rdata_src;

`ifdef YCR1_SRAM_RDATA_REG_EN
    logic [31:0] rdata_reg;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rdata_reg <= 32'd0;
        end else if (state_reg == ST_RDREG) begin
            rdata_reg <= sram_dout_i;
        end
    end

    assign rdata_src = rdata_reg;
`else
    assign rdata_src = sram_dout_i;
`endif

    // Read data is only driven during a read ack; writes and errors return zero.
    always_comb begin
        wbd_dat_o = 32'd0;
        if (ack_reg && rd_reg) begin
            wbd_dat_o = rdata_src;
        end
    end

    assign wbd_ack_o    = ack_reg;
    assign wbd_err_o    = err_reg;
    assign sram_csb_o   = csb_reg;
    assign sram_web_o   = web_reg;
    assign sram_wmask_o = wmask_reg;
    assign sram_addr_o  = addr_reg;
    assign sram_din_o   = din_reg;

endmodule
